// File: rtl/jtag_reg_bank.sv
// -----------------------------------------------------------------------------
// jtag_reg_bank
//
// Addressed register bank reached through a BSCANE2 USER data register.
// Each DR frame is {wr, addr, data}, shifted LSB first. The capture phase loads
// {frame_err, rd_addr, status word at rd_addr}. The host therefore reads back
// the status word it addressed in the previous frame, and it sees any
// length error from that frame. The update phase checks the frame length.
// A correctly sized write frame loads one control register. A frame of the
// wrong length is discarded and sets the sticky frame_err flag.
//
// Ports
//   tck         JTAG TCK from BSCANE2; the only clock, all logic on posedge
//   tck_resetn  asynchronous active-low reset
//   sel         BSCANE2 SEL; capture/shift/update only act while high
//   capture     BSCANE2 CAPTURE
//   shift       BSCANE2 SHIFT
//   update      BSCANE2 UPDATE
//   tdi         BSCANE2 TDI
//   tdo         to BSCANE2 TDO, driven straight from shift register bit 0
//   stat_in     status words, word i at [i*JDATA_WIDTH +: JDATA_WIDTH]
//   ctrl_out    control registers, same packing as stat_in
//   wr_strobe   one-cycle pulse after each accepted control write
//   wr_addr     address of the most recent accepted write
//   frame_err   sticky flag: last updated frame had the wrong length
// -----------------------------------------------------------------------------
module jtag_reg_bank #(
    parameter int                     JDATA_WIDTH = 32,
    parameter int                     JADDR_WIDTH = 2,
    parameter int                     NUM_REGS    = 4,
    parameter logic [JDATA_WIDTH-1:0] CTRL_RESET  = '0
) (
    input  logic                            tck,
    input  logic                            tck_resetn,
    input  logic                            sel,
    input  logic                            capture,
    input  logic                            shift,
    input  logic                            update,
    input  logic                            tdi,
    output logic                            tdo,
    input  logic [NUM_REGS*JDATA_WIDTH-1:0] stat_in,
    output logic [NUM_REGS*JDATA_WIDTH-1:0] ctrl_out,
    output logic                            wr_strobe,
    output logic [JADDR_WIDTH-1:0]          wr_addr,
    output logic                            frame_err
);

    // Frame length and the bit counter that measures it. The counter
    // saturates at F+1 so that any over-length frame stays distinguishable
    // from a correct one no matter how many extra bits the host shifts.
    localparam int F     = JDATA_WIDTH + JADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(F + 2);

    localparam logic [CNT_W-1:0]     CNT_FRAME  = CNT_W'(F);
    localparam logic [CNT_W-1:0]     CNT_SAT    = CNT_W'(F + 1);
    localparam logic [JADDR_WIDTH:0] NUM_REGS_W = (JADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOADED   = 2'd1,
        SHIFTING = 2'd2
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic [F-1:0]             sr_reg;
    logic [CNT_W-1:0]         bit_cnt_reg;
    logic [JADDR_WIDTH-1:0]   rd_addr_reg;
    logic                     frame_err_reg;
    logic                     wr_strobe_reg;
    logic [JADDR_WIDTH-1:0]   wr_addr_reg;

    logic [JDATA_WIDTH-1:0]   rd_data;
    logic [JDATA_WIDTH-1:0]   frame_data;
    logic [JADDR_WIDTH-1:0]   frame_addr;
    logic                     frame_wr;
    logic                     frame_ok;
    logic                     addr_in_range;
    logic                     do_capture;
    logic                     do_update;
    logic                     do_shift;
    logic                     do_write;

    // Fields of the frame currently held in the shift register.
    assign frame_data = sr_reg[JDATA_WIDTH-1:0];
    assign frame_addr = sr_reg[JDATA_WIDTH +: JADDR_WIDTH];
    assign frame_wr   = sr_reg[F-1];

    assign frame_ok      = (bit_cnt_reg == CNT_FRAME);
    assign addr_in_range = ({1'b0, frame_addr} < NUM_REGS_W);

    // The priority is capture > update > shift. An update in IDLE still
    // pre-empts a shift in the same cycle, but it has no effect of its own.
    assign do_capture = sel & capture;
    assign do_update  = sel & ~capture & update & (state_reg != IDLE);
    assign do_shift   = sel & ~capture & ~update & shift;
    assign do_write   = do_update & frame_ok & frame_wr & addr_in_range;

    // Read mux. An address beyond the implemented registers reads as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, rd_addr_reg} == (JADDR_WIDTH + 1)'(i)) begin
                rd_data = stat_in[i*JDATA_WIDTH +: JDATA_WIDTH];
            end
        end
    end

    // Frame sequencing state.
    always_ff @(posedge tck or negedge tck_resetn) begin
        if (!tck_resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (sel) begin
            if (capture) begin
                state_next = LOADED;
            end else if (update) begin
                if (state_reg != IDLE) begin
                    state_next = IDLE;
                end
            end else if (shift) begin
                if (state_reg == LOADED) begin
                    state_next = SHIFTING;
                end
            end
        end
    end

    // Shift register, length check, read pointer, error flag and write
    // handshake. While sel is low no do_* term is active, so everything holds
    // except the strobe, which drops back to zero.
    always_ff @(posedge tck or negedge tck_resetn) begin
        if (!tck_resetn) begin
            sr_reg        <= '0;
            bit_cnt_reg   <= '0;
            rd_addr_reg   <= '0;
            frame_err_reg <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
        end else begin
            wr_strobe_reg <= 1'b0;
            if (do_capture) begin
                // The error flag goes into the wr position so the host sees
                // it in the next frame before a good frame clears it.
                sr_reg      <= {frame_err_reg, rd_addr_reg, rd_data};
                bit_cnt_reg <= '0;
            end else if (do_update) begin
                if (frame_ok) begin
                    rd_addr_reg   <= frame_addr;
                    frame_err_reg <= 1'b0;
                    if (do_write) begin
                        wr_addr_reg   <= frame_addr;
                        wr_strobe_reg <= 1'b1;
                    end
                end else begin
                    frame_err_reg <= 1'b1;
                end
            end else if (do_shift) begin
                sr_reg <= {tdi, sr_reg[F-1:1]};
                if (bit_cnt_reg != CNT_SAT) begin
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Control registers. Each one loads only on an accepted write to its
    // own address.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_ctrl
            logic [JDATA_WIDTH-1:0] ctrl_reg;

            always_ff @(posedge tck or negedge tck_resetn) begin
                if (!tck_resetn) begin
                    ctrl_reg <= CTRL_RESET;
                end else if (do_write && (frame_addr == JADDR_WIDTH'(gi))) begin
                    ctrl_reg <= frame_data;
                end
            end

            assign ctrl_out[gi*JDATA_WIDTH +: JDATA_WIDTH] = ctrl_reg;
        end
    endgenerate

    assign tdo       = sr_reg[0];
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_jtag_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_jtag_reg_bank
//
// Scoreboard bench for jtag_reg_bank (32-bit data, 2-bit address, 3 registers).
// The stimulus tasks push the expected values into three queues:
//   frame_q  expected captured word, compared against the tdo bits seen
//            during the shift phase
//   wr_q     expected write events, one per wr_strobe cycle
//   snap_q   expected {tdo, frame_err, wr_addr, ctrl_out} at a snapshot point
// A separate monitor pops and compares each entry when the DUT presents it.
// -----------------------------------------------------------------------------
module tb_jtag_reg_bank;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int NR = 3;
    localparam int F  = DW + AW + 1;

    logic              tck = 1'b0;
    logic              tck_resetn;
    logic              sel;
    logic              capture;
    logic              shift;
    logic              update;
    logic              tdi;
    logic              tdo;
    logic [NR*DW-1:0]  stat_in;
    logic [NR*DW-1:0]  ctrl_out;
    logic              wr_strobe;
    logic [AW-1:0]     wr_addr;
    logic              frame_err;

    always #5 tck = ~tck;

    jtag_reg_bank #(
        .JDATA_WIDTH (DW),
        .JADDR_WIDTH (AW),
        .NUM_REGS    (NR),
        .CTRL_RESET  ('0)
    ) dut (
        .tck        (tck),
        .tck_resetn (tck_resetn),
        .sel        (sel),
        .capture    (capture),
        .shift      (shift),
        .update     (update),
        .tdi        (tdi),
        .tdo        (tdo),
        .stat_in    (stat_in),
        .ctrl_out   (ctrl_out),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .frame_err  (frame_err)
    );

    typedef struct {
        string        name;
        logic [F-1:0] exp;
        int           len;
    } frame_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        string      name;
        logic [99:0] exp;
    } snap_t;

    frame_t frame_q[$];
    wr_t    wr_q[$];
    snap_t  snap_q[$];

    int total = 0;
    int bad   = 0;
    bit snap_req = 1'b0;

    // Reference state that the stimulus keeps up to date.
    logic [DW-1:0] m_ctrl [NR];
    logic [AW-1:0] m_rd_addr;
    logic [AW-1:0] m_wr_addr;
    logic          m_err;
    logic [F-1:0]  m_sr;

    function automatic logic [99:0] m_obs();
        return {m_sr[0], m_err, m_wr_addr, m_ctrl[2], m_ctrl[1], m_ctrl[0]};
    endfunction

    // ---------------- monitor ----------------
    logic [F-1:0] mon_buf;
    logic [F-1:0] mon_mask;
    int           mon_cnt;
    bit           mon_in_frame = 1'b0;
    frame_t       mf;
    wr_t          mw;
    snap_t        ms;
    logic [DW-1:0] mon_word;

    always @(negedge tck) begin
        // Collect the tdo bits of each frame and check them at update.
        if (!tck_resetn) begin
            mon_in_frame = 1'b0;
        end else if (sel) begin
            if (capture) begin
                mon_in_frame = 1'b1;
                mon_cnt      = 0;
                mon_buf      = '0;
            end else if (update) begin
                if (mon_in_frame) begin
                    if (frame_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_unexpected: got update with no expected frame queued");
                    end else begin
                        mf = frame_q.pop_front();
                        if (mf.len > 0) begin
                            mon_mask = '0;
                            for (int i = 0; i < mf.len && i < F; i++) mon_mask[i] = 1'b1;
                            total++;
                            if ((mon_buf & mon_mask) !== (mf.exp & mon_mask)) begin
                                bad++;
                                $display("FAIL frame %s: got tdo bits %h want %h",
                                         mf.name, mon_buf & mon_mask, mf.exp & mon_mask);
                            end
                        end
                    end
                    mon_in_frame = 1'b0;
                end
            end else if (shift && mon_in_frame) begin
                if (mon_cnt < F) mon_buf[mon_cnt] = tdo;
                mon_cnt++;
            end
        end

        // Every strobe cycle must match exactly one expected write.
        if (wr_strobe !== 1'b0) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL wr_strobe_unexpected: got wr_strobe=%b wr_addr=%0d want no strobe",
                         wr_strobe, wr_addr);
            end else begin
                mw       = wr_q.pop_front();
                mon_word = ctrl_out[mw.addr*DW +: DW];
                if ({wr_addr, mon_word} !== {mw.addr, mw.data}) begin
                    bad++;
                    $display("FAIL wr_event: got addr=%0d data=%h want addr=%0d data=%h",
                             wr_addr, mon_word, mw.addr, mw.data);
                end
            end
        end

        // Snapshot requested by the stimulus.
        if (snap_req) begin
            snap_req = 1'b0;
            total++;
            if (snap_q.size() == 0) begin
                bad++;
                $display("FAIL snap_unexpected: got request with no expected entry");
            end else begin
                ms = snap_q.pop_front();
                if ({tdo, frame_err, wr_addr, ctrl_out} !== ms.exp) begin
                    bad++;
                    $display("FAIL snap %s: got %h want %h", ms.name,
                             {tdo, frame_err, wr_addr, ctrl_out}, ms.exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic c, input logic s, input logic u, input logic t);
        capture = c;
        shift   = s;
        update  = u;
        tdi     = t;
        @(posedge tck);
        #1;
    endtask

    task automatic snap(input string name);
        snap_t e;
        e.name = name;
        e.exp  = m_obs();
        snap_q.push_back(e);
        snap_req = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_ctrl[i] = '0;
        m_rd_addr = '0;
        m_wr_addr = '0;
        m_err     = 1'b0;
        m_sr      = '0;
    endtask

    // One complete frame: capture, nbits shifts, update.
    task automatic do_frame(input string name, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int nbits);
        logic [F-1:0]  fw;
        logic [F-1:0]  cap;
        logic [DW-1:0] rdw;
        logic          b;
        frame_t        fe;
        wr_t           we;
        fw  = {w, a, d};
        rdw = (m_rd_addr < NR) ? stat_in[m_rd_addr*DW +: DW] : '0;
        cap = {m_err, m_rd_addr, rdw};
        step(1'b1, 1'b0, 1'b0, 1'b0);
        m_sr = cap;
        for (int k = 0; k < nbits; k++) begin
            b = (k < F) ? fw[k] : 1'b0;
            step(1'b0, 1'b1, 1'b0, b);
            m_sr = {b, m_sr[F-1:1]};
        end
        fe.name = name;
        fe.exp  = cap;
        fe.len  = (nbits < F) ? nbits : F;
        frame_q.push_back(fe);
        if (nbits == F) begin
            m_rd_addr = a;
            m_err     = 1'b0;
            if (w && (a < NR)) begin
                m_ctrl[a] = d;
                m_wr_addr = a;
                we.addr   = a;
                we.data   = d;
                wr_q.push_back(we);
            end
        end else begin
            m_err = 1'b1;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish within 200000 time units want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [F-1:0] fw;
        tck_resetn = 1'b0;
        sel        = 1'b0;
        capture    = 1'b0;
        shift      = 1'b0;
        update     = 1'b0;
        tdi        = 1'b0;
        stat_in    = {32'h12345678, 32'h0BADF00D, 32'hA5A50001};
        model_reset();

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        snap("reset_state");
        tck_resetn = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // sel low: capture/shift/update must all be ignored.
        for (int k = 0; k < 15; k++) begin
            step((k % 5) == 0, (k % 5) inside {[1:3]}, (k % 5) == 4, 1'b1);
        end
        snap("sel_low_hold");

        sel = 1'b1;
        do_frame("wr_a1_deadbeef", 1'b1, 2'd1, 32'hDEADBEEF, F);
        snap("after_write_a1");
        do_frame("rd_set_a2", 1'b0, 2'd2, 32'h0, F);
        do_frame("rd_get_a2", 1'b0, 2'd2, 32'h0, F);

        do_frame("short_34", 1'b1, 2'd0, 32'hCAFE0000, F - 1);
        snap("after_short");
        do_frame("err_reported", 1'b0, 2'd0, 32'h0, F);
        snap("err_cleared");

        do_frame("wr_a3_out_of_range", 1'b1, 2'd3, 32'hFFFFFFFF, F);
        snap("after_oor");
        do_frame("rd_a3_zero", 1'b0, 2'd1, 32'h0, F);

        do_frame("zero_bit", 1'b0, 2'd0, 32'h0, 0);
        do_frame("long_40", 1'b1, 2'd2, 32'h55AA55AA, F + 5);
        snap("after_long");

        do_frame("b2b_a0", 1'b1, 2'd0, 32'h11111111, F);
        do_frame("b2b_a2", 1'b1, 2'd2, 32'h22222222, F);
        snap("after_b2b");

        // Reset in the middle of a write frame: no write may happen.
        fw = {1'b1, 2'd2, 32'h9999AAAA};
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b0, fw[k]);
        #2;
        tck_resetn = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        snap("reset_midframe");
        tck_resetn = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        snap("update_idle_ignored");
        do_frame("post_reset_rd", 1'b0, 2'd0, 32'h0, F);

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

        total++;
        if (frame_q.size() != 0) begin
            bad++;
            $display("FAIL frames_left: got %0d unchecked frames want 0", frame_q.size());
        end
        total++;
        if (wr_q.size() != 0) begin
            bad++;
            $display("FAIL writes_missing: got %0d writes without strobe want 0", wr_q.size());
        end
        total++;
        if (snap_q.size() != 0) begin
            bad++;
            $display("FAIL snaps_left: got %0d unchecked snapshots want 0", snap_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
